// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV64 funct3 codes
// and size helpers. Build option: LSU_MISALIGN_CHECK_EN adds the ERR state.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_D  = 3'd3;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;
   localparam logic [2:0] F3_WU = 3'd6;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      RESP
`ifdef LSU_MISALIGN_CHECK_EN
      ,ERR
`endif
   } lsu_state_e;

   // Access size in bytes; code 7 falls through to a doubleword.
   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'd0:    return 4'd1;
         2'd1:    return 4'd2;
         2'd2:    return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   // Only lb/lh/lw sign-extend; everything else (incl. illegal 7) is zero-extended.
   function automatic logic is_signed_load(input logic [2:0] funct3);
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
   endfunction

   // Stores have no unsigned variants: codes 4..7 are treated as sd.
   function automatic logic [2:0] store_f3_norm(input logic [2:0] funct3);
      return funct3[2] ? F3_D : funct3;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: extracts and extends load data from a doubleword, and
// merges right-aligned store data into a doubleword for read-modify-write.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0] word,
   input  logic [DATA_W-1:0] wdata,
   input  logic [2:0]        off,
   input  logic [2:0]        funct3,
   output logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] merged_wd
);

   logic [5:0]        sh_amt;
   logic [DATA_W-1:0] word_sh;
   logic [DATA_W-1:0] wdata_sh;
   logic [3:0]        size;
   logic              sgn;
   logic [7:0]        lane_base;
   logic [7:0]        lane_mask;

   assign sh_amt   = {off, 3'b000};
   assign word_sh  = word >> sh_amt;
   assign wdata_sh = wdata << sh_amt;
   assign size     = size_bytes(funct3);
   assign sgn      = is_signed_load(funct3);

   // Byte-enable mask for the lanes a store of this size overwrites.
   always_comb begin
      lane_base = 8'hFF;
      case (size)
         4'd1:    lane_base = 8'h01;
         4'd2:    lane_base = 8'h03;
         4'd4:    lane_base = 8'h0F;
         default: lane_base = 8'hFF;
      endcase
      lane_mask = lane_base << off;
   end

   // Load extract: lane already shifted to bit 0, now mask and extend.
   always_comb begin
      load_data = word_sh;
      case (size)
         4'd1:    load_data = {{(DATA_W-8){sgn & word_sh[7]}},   word_sh[7:0]};
         4'd2:    load_data = {{(DATA_W-16){sgn & word_sh[15]}}, word_sh[15:0]};
         4'd4:    load_data = {{(DATA_W-32){sgn & word_sh[31]}}, word_sh[31:0]};
         default: load_data = word_sh;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_merge
         assign merged_wd[8*gi +: 8] = lane_mask[gi] ? wdata_sh[8*gi +: 8] : word[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/lsu_master.sv
// Load/store initiator between the core memory stage and a 64-bit data
// memory. One request in flight; sub-doubleword stores use read-modify-write.
// Build option: LSU_MISALIGN_CHECK_EN flags misaligned accesses through an
// ERR response instead of force-aligning the byte offset.
module lsu_master
   import lsu_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [63:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wd,
   input  logic [DATA_W-1:0]     mem_rd
);

   lsu_state_e state_q, state_d;

   logic [DM_ADDRESS-1:0] idx_q;
   logic [2:0]            off_q;
   logic                  we_q;
   logic [2:0]            f3_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W-1:0]     word_q;
   logic [DATA_W-1:0]     rdata_q;

   logic                  accept;
   logic [2:0]            req_f3_n;
   logic [3:0]            req_size;
   logic [2:0]            req_sz_m1;
   logic [2:0]            req_off_al;
   logic [DATA_W-1:0]     align_word;
   logic [DATA_W-1:0]     load_data;
   logic [DATA_W-1:0]     merged_wd;
   logic                  unused_addr_hi;

   // Address bits above the memory index wrap around.
   assign unused_addr_hi = ^req_addr[63:DM_ADDRESS+3];

   assign req_ready  = (state_q == IDLE);
   assign accept     = req_valid && req_ready;
   assign req_f3_n   = req_we ? store_f3_norm(req_funct3) : req_funct3;
   assign req_size   = size_bytes(req_f3_n);
   assign req_sz_m1  = 3'(req_size - 4'd1);
   assign req_off_al = req_addr[2:0] & ~req_sz_m1;

`ifdef LSU_MISALIGN_CHECK_EN
   logic req_misaligned;
   assign req_misaligned = |(req_addr[2:0] & req_sz_m1);
`endif

   // In RD the live memory word is aligned; in WR the captured word is merged.
   assign align_word = (state_q == RD) ? mem_rd : word_q;
   assign resp_rdata = rdata_q;

   lsu_lane_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .word      (align_word),
      .wdata     (wdata_q),
      .off       (off_q),
      .funct3    (f3_q),
      .load_data (load_data),
      .merged_wd (merged_wd)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture, RMW word capture and load result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q   <= '0;
         off_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            idx_q   <= req_addr[DM_ADDRESS+2:3];
            off_q   <= req_off_al;
            we_q    <= req_we;
            f3_q    <= req_f3_n;
            wdata_q <= req_wdata;
            rdata_q <= '0;
         end
         if (state_q == RD) begin
            if (we_q) begin
               word_q <= mem_rd;
            end else begin
               rdata_q <= load_data;
            end
         end
      end
   end

   // Next-state and memory/response strobes.
   always_comb begin
      state_d    = state_q;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_wd     = '0;
      mem_addr   = '0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      if (state_q != IDLE) begin
         mem_addr = idx_q;
      end
      case (state_q)
         IDLE: begin
            if (req_valid) begin
`ifdef LSU_MISALIGN_CHECK_EN
               if (req_misaligned) begin
                  state_d = ERR;
               end else
`endif
               if (req_we && (req_f3_n == F3_D)) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            mem_read = 1'b1;
            state_d  = we_q ? WR : RESP;
         end
         WR: begin
            mem_write = 1'b1;
            mem_wd    = (f3_q == F3_D) ? wdata_q : merged_wd;
            state_d   = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
`ifdef LSU_MISALIGN_CHECK_EN
         ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            state_d    = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master with a behavioural 512 x 64 data memory.
module tb_lsu_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [8:0]  mem_addr;
   logic [63:0] mem_wd;
   logic [63:0] mem_rd;

   logic [63:0] mem [0:511];
   logic        poke_en = 1'b0;
   logic [8:0]  poke_idx = '0;
   logic [63:0] poke_val = '0;

   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
   int n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   lsu_master #(.DM_ADDRESS(9), .DATA_W(64)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   assign mem_rd = mem[mem_addr];

   always @(posedge clk) begin
      if (poke_en) mem[poke_idx] <= poke_val;
      else if (mem_write) mem[mem_addr] <= mem_wd;
   end

   always @(posedge clk) begin
      if (mem_read) rd_cnt <= rd_cnt + 1;
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (mem_read && mem_write) both_cnt <= both_cnt + 1;
   end

   task automatic poke(input int idx, input logic [63:0] v);
      poke_en = 1'b1; poke_idx = idx[8:0]; poke_val = v;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   // Issues one request from IDLE and follows it back to IDLE.
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, output int lat, output logic [63:0] rdata,
                          output logic err, output int nrd, output int nwr, output int nboth,
                          output logic rd_c1);
      int r0, w0, b0;
      r0 = rd_cnt; w0 = wr_cnt; b0 = both_cnt;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rd_c1 = mem_read;
      lat = 1; rdata = '0; err = 1'b0;
      while (!resp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (resp_valid) begin
         rdata = resp_rdata; err = resp_err;
      end else begin
         lat = -1;
      end
      @(posedge clk); #1;
      nrd = rd_cnt - r0; nwr = wr_cnt - w0; nboth = both_cnt - b0;
      $display("txn we=%0d f3=%0d addr=%h wd=%h lat=%0d rdata=%h err=%0d rd=%0d wr=%0d",
               we, f3, addr, wd, lat, rdata, err, nrd, nwr);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
      n_cmp++;
      if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
      n_cmp++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      n_cmp++;
      if (resp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
      n_cmp++;
      if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
      n_cmp++;
      if (mem_addr !== 9'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      n_cmp++;
      if (mem_wd !== 64'd0) begin n_fail++; $display("FAIL reset_mem_wd: got %h want 0", mem_wd); end
      n_cmp++;
      reset = 1'b0;
      @(posedge clk); #1;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      n_cmp++;
   endtask

   task automatic test_load_dword();
      int lat, nrd, nwr, nb; logic [63:0] rd; logic err, c1;
      poke(5, 64'h8899AABBCCDDEEFF);
      run_req(1'b0, 3'd3, 64'h28, 64'h0, lat, rd, err, nrd, nwr, nb, c1);
      if (c1 !== 1'b1) begin n_fail++; $display("FAIL ld_read_cycle1: got %b want 1", c1); end
      n_cmp++;
      if (lat !== 2) begin n_fail++; $display("FAIL ld_latency: got %0d want 2", lat); end
      n_cmp++;
      if (rd !== 64'h8899AABBCCDDEEFF) begin n_fail++; $display("FAIL ld_data: got %h want 8899aabbccddeeff", rd); end
      n_cmp++;
      if (nwr !== 0) begin n_fail++; $display("FAIL ld_no_write: got %0d want 0", nwr); end
      n_cmp++;
      // Address bit 12 lies above the index and must wrap to mem[5].
      run_req(1'b0, 3'd3, 64'h1028, 64'h0, lat, rd, err, nrd, nwr, nb, c1);
      if (rd !== 64'h8899AABBCCDDEEFF) begin n_fail++; $display("FAIL ld_wrap: got %h want 8899aabbccddeeff", rd); end
      n_cmp++;
   endtask

   task automatic test_extend();
      int lat, nrd, nwr, nb; logic [63:0] rd; logic err, c1;
      poke(0, 64'h0000_0000_0000_80F0);
      run_req(1'b0, 3'd0, 64'h1, 64'h0, lat, rd, err, nrd, nwr, nb, c1);
      if (rd !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb: got %h want ffffffffffffff80", rd); end
      n_cmp++;
      run_req(1'b0, 3'd4, 64'h1, 64'h0, lat, rd, err, nrd, nwr, nb, c1);
      if (rd !== 64'h0000_0000_0000_0080) begin n_fail++; $display("FAIL lbu: got %h want 80", rd); end
      n_cmp++;
      run_req(1'b0, 3'd1, 64'h0, 64'h0, lat, rd, err, nrd, nwr, nb, c1);
      if (rd !== 64'hFFFF_FFFF_FFFF_80F0) begin n_fail++; $display("FAIL lh: got %h want ffffffffffff80f0", rd); end
      n_cmp++;
      run_req(1'b0, 3'd5, 64'h0, 64'h0, lat, rd, err, nrd, nwr, nb, c1);
      if (rd !== 64'h0000_0000_0000_80F0) begin n_fail++; $display("FAIL lhu: got %h want 80f0", rd); end
      n_cmp++;
   endtask

   task automatic test_rmw();
      int lat, nrd, nwr, nb; logic [63:0] rd; logic err, c1;
      poke(2, 64'h1111111122222222);
      run_req(1'b1, 3'd1, 64'h14, 64'hFFFF_FFFF_FFFF_ABCD, lat, rd, err, nrd, nwr, nb, c1);
      if (nwr !== 1) begin n_fail++; $display("FAIL sh_write_pulses: got %0d want 1", nwr); end
      n_cmp++;
      if (nb !== 0) begin n_fail++; $display("FAIL sh_read_and_write: got %0d want 0", nb); end
      n_cmp++;
      if (lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d want 3", lat); end
      n_cmp++;
      if (rd !== 64'd0) begin n_fail++; $display("FAIL sh_rdata: got %h want 0", rd); end
      n_cmp++;
      if (mem[2] !== 64'h1111ABCD22222222) begin n_fail++; $display("FAIL sh_mem: got %h want 1111abcd22222222", mem[2]); end
      n_cmp++;
      run_req(1'b1, 3'd0, 64'h17, 64'h0000_0000_0000_0077, lat, rd, err, nrd, nwr, nb, c1);
      if (mem[2] !== 64'h7711ABCD22222222) begin n_fail++; $display("FAIL sb_mem: got %h want 7711abcd22222222", mem[2]); end
      n_cmp++;
      run_req(1'b1, 3'd2, 64'h10, 64'hFFFF_FFFF_DEAD_BEEF, lat, rd, err, nrd, nwr, nb, c1);
      if (mem[2] !== 64'h7711ABCDDEADBEEF) begin n_fail++; $display("FAIL sw_mem: got %h want 7711abcddeadbeef", mem[2]); end
      n_cmp++;
      // Store code 5 is illegal and behaves as a plain doubleword store.
      poke(3, 64'h0);
      run_req(1'b1, 3'd5, 64'h18, 64'h0123456789ABCDEF, lat, rd, err, nrd, nwr, nb, c1);
      if (lat !== 2) begin n_fail++; $display("FAIL st_illegal_latency: got %0d want 2", lat); end
      n_cmp++;
      if (mem[3] !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL st_illegal_mem: got %h want 0123456789abcdef", mem[3]); end
      n_cmp++;
      run_req(1'b0, 3'd7, 64'h18, 64'h0, lat, rd, err, nrd, nwr, nb, c1);
      if (rd !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL ld_illegal: got %h want 0123456789abcdef", rd); end
      n_cmp++;
   endtask

   task automatic test_back_to_back();
      poke(8, 64'h0);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd3; req_addr = 64'h40; req_wdata = 64'hCAFEF00D12345678;
      @(posedge clk); #1;
      if (req_ready !== 1'b0 || mem_write !== 1'b1) begin
         n_fail++; $display("FAIL b2b_wr_cycle: got ready=%b write=%b want ready=0 write=1", req_ready, mem_write);
      end
      n_cmp++;
      req_we = 1'b0;
      @(posedge clk); #1;
      if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
         n_fail++; $display("FAIL b2b_sd_resp: got ready=%b valid=%b want ready=0 valid=1", req_ready, resp_valid);
      end
      n_cmp++;
      @(posedge clk); #1;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_sd: got %b want 1", req_ready); end
      n_cmp++;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_read !== 1'b1) begin n_fail++; $display("FAIL b2b_ld_read: got %b want 1", mem_read); end
      n_cmp++;
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'hCAFEF00D12345678) begin
         n_fail++; $display("FAIL b2b_ld_data: got valid=%b data=%h want valid=1 data=cafef00d12345678", resp_valid, resp_rdata);
      end
      n_cmp++;
      @(posedge clk); #1;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_ld: got %b want 1", req_ready); end
      n_cmp++;
      $display("txn b2b sd+ld addr=40 rdata=%h", resp_rdata);
   endtask

   task automatic test_reset_mid_store();
      int w0;
      poke(6, 64'h0123_4567_89AB_CDEF);
      w0 = wr_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 64'h33; req_wdata = 64'h5A;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_rd: got %b want 1", mem_read); end
      n_cmp++;
      reset = 1'b1;
      @(posedge clk); #1;
      if (mem_write !== 1'b0 || mem_read !== 1'b0 || resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_strobes: got wr=%b rd=%b valid=%b want 0 0 0", mem_write, mem_read, resp_valid);
      end
      n_cmp++;
      reset = 1'b0;
      @(posedge clk); #1;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
      n_cmp++;
      repeat (3) @(posedge clk);
      #1;
      if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL rst_mid_no_write: got %0d want 0", wr_cnt - w0); end
      n_cmp++;
      if (mem[6] !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL rst_mid_mem: got %h want 0123456789abcdef", mem[6]); end
      n_cmp++;
      $display("txn sb addr=33 aborted by reset mem6=%h", mem[6]);
   endtask

   task automatic test_misalign();
      int lat, nrd, nwr, nb; logic [63:0] rd; logic err, c1;
      poke(0, 64'h8877665544332211);
      run_req(1'b0, 3'd2, 64'h6, 64'h0, lat, rd, err, nrd, nwr, nb, c1);
`ifdef LSU_MISALIGN_CHECK_EN
      if (lat !== 1) begin n_fail++; $display("FAIL mis_latency: got %0d want 1", lat); end
      n_cmp++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b want 1", err); end
      n_cmp++;
      if (rd !== 64'd0) begin n_fail++; $display("FAIL mis_rdata: got %h want 0", rd); end
      n_cmp++;
      if (nrd !== 0) begin n_fail++; $display("FAIL mis_no_read: got %0d want 0", nrd); end
      n_cmp++;
`else
      if (lat !== 2) begin n_fail++; $display("FAIL mis_latency: got %0d want 2", lat); end
      n_cmp++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL mis_err: got %b want 0", err); end
      n_cmp++;
      if (rd !== 64'hFFFF_FFFF_8877_6655) begin n_fail++; $display("FAIL mis_rdata: got %h want ffffffff88776655", rd); end
      n_cmp++;
      if (nrd !== 1) begin n_fail++; $display("FAIL mis_read: got %0d want 1", nrd); end
      n_cmp++;
`endif
   endtask

   initial begin
      test_reset();
      test_load_dword();
      test_extend();
      test_rmw();
      test_back_to_back();
      test_reset_mid_store();
      test_misalign();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Load/store initiator between the core's memory stage and the 64-bit data memory.
- Accepts one load/store request at a time and drives the memory's read-enable, write-enable, doubleword address and write data.
- Performs byte-lane extract with sign/zero extension for loads, and read-modify-write for sub-doubleword stores.
- Returns a single-cycle response to the core.

Parameters:
- DM_ADDRESS, 9: width of the memory doubleword index (`mem_addr`).
- DATA_W, 64: data width; the only supported value is 64.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high reset.
- `req_valid`, input, 1: core request present.
- `req_ready`, output, 1: block accepts a request this cycle.
- `req_we`, input, 1: 1 = store, 0 = load.
- `req_funct3`, input, 3: RV64 size/sign code (0 lb/sb, 1 lh/sh, 2 lw/sw, 3 ld/sd, 4 lbu, 5 lhu, 6 lwu).
- `req_addr`, input, 64: byte address.
- `req_wdata`, input, DATA_W: store data, right-aligned.
- `resp_valid`, output, 1: one-cycle completion pulse.
- `resp_rdata`, output, DATA_W: extended load data; 0 for stores.
- `resp_err`, output, 1: misaligned access (only with the optional feature).
- `mem_read`, output, 1: memory read enable.
- `mem_write`, output, 1: memory write enable.
- `mem_addr`, output, DM_ADDRESS: doubleword index = `req_addr[DM_ADDRESS+2:3]`.
- `mem_wd`, output, DATA_W: memory write data.
- `mem_rd`, input, DATA_W: memory read data, combinational from `mem_addr` while `mem_read` = 1.

Behaviour:
- Reset: all outputs 0 except `req_ready`. `req_ready` = 1 from the first cycle after reset deasserts. State = IDLE. Captured request registers cleared.
- Accept: handshake when `req_valid` && `req_ready`. Address, we, funct3 and wdata are registered at acceptance. `req_ready` = 1 only in IDLE.
- Lane offset: `off = addr[2:0]`, byte lane = `off`.
- States: IDLE, RD, WR, RESP (plus ERR when `LSU_MISALIGN_CHECK_EN` is defined).
- Load path: IDLE → RD → RESP.
  - RD: `mem_read` = 1; `mem_rd` shifted right by `8*off`, masked to size, sign- or zero-extended per funct3, and registered into `resp_rdata`.
  - RESP: `resp_valid` = 1 for one cycle.
  - Latency: `resp_valid` appears 2 cycles after the accept edge.
- Doubleword store (funct3 = 3): IDLE → WR → RESP.
  - WR: `mem_write` = 1, `mem_wd` = wdata.
- Sub-doubleword store (funct3 0, 1, 2): IDLE → RD → WR → RESP.
  - RD: captures `mem_rd`.
  - WR: `mem_wd` = captured word with bytes `[off .. off+size-1]` replaced by the low `size` bytes of wdata; all other bytes are preserved.
- `mem_read` and `mem_write` are never both 1. Both are 0 in IDLE and RESP.
- `mem_addr` holds the captured index in every non-IDLE state and is 0 in IDLE.
- RESP → IDLE unconditionally. There is no response backpressure.
- Illegal funct3 (7 for loads; 4–7 for stores): treated as doubleword size, zero-extended.
- Reset asserted mid-operation: state → IDLE on that edge. `mem_write`, `mem_read` and `resp_valid` are 0 on the following cycle. The in-flight request is dropped and no partial write occurs.
- Address bits above `DM_ADDRESS+2` are ignored (wrap-around).

Optional Feature:
- Macro: `LSU_MISALIGN_CHECK_EN`.
- Defined:
  - An accepted request whose `off` is not a multiple of its size goes IDLE → ERR → IDLE.
  - ERR: `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0.
  - No memory access is made.
- Undefined:
  - The ERR state is absent and `resp_err` is tied to 0.
  - `off` is force-aligned by clearing its low log2(size) bits.

Decomposition:
- Package `lsu_pkg`:
  - `lsu_state_e` enum.
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`).
  - Function `size_bytes(funct3)`.
- Sub-module `lsu_lane_align` (combinational): load extract/extend and store byte merge. Inputs: word, wdata, off, funct3. Outputs: `load_data`, `merged_wd`.

Test Plan:
- Load dword: mem[5] = 64'h8899AABBCCDDEEFF; ld at addr 0x28 → `mem_read` on the cycle after accept; `resp_valid` 2 cycles after accept; `resp_rdata` = 64'h8899AABBCCDDEEFF.
- Sign vs zero extension: mem[0] = 64'h0000_0000_0000_80F0; lb at addr 1 → FFFF_FFFF_FFFF_FF80; lbu at addr 1 → 0000_0000_0000_0080; lh at addr 0 → FFFF_FFFF_FFFF_80F0.
- Read-modify-write: mem[2] = 64'h1111111122222222; sh wdata = 0xABCD at addr 0x14 → exactly one `mem_write` pulse; mem[2] = 64'h1111ABCD22222222; no cycle has `mem_read` && `mem_write`.
- Back-to-back: `req_valid` held high with sd then ld to the same address → `req_ready` low during the busy states; ld returns the stored value; 3 + 3 cycles total.
- Reset mid-store: assert `reset` in the RD state of an sb → no `mem_write` occurs; memory unchanged; `req_ready` = 1 the cycle after reset drops.
- With `LSU_MISALIGN_CHECK_EN`: lw at addr 0x6 → `resp_valid` = 1 and `resp_err` = 1 one cycle after accept; no `mem_read`. Without the macro: the same request reads bytes 4–7.
